mesh_avg_engine: RTL and testbench
==================================

MESH_AVG_ENGINE -- requirements
Module: mesh_avg_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 9: RAM word address width, 512-deep DFFRAM.
REQ-002 SHALL have parameter DATA_W, default 32: RAM word width.
REQ-003 SHALL have parameter COORD_W, default 10: signed x/y/z field width; x=[3*COORD_W-1:2*COORD_W], y=[2*COORD_W-1:COORD_W], z=[COORD_W-1:0]; unused upper bits are 0.
REQ-004 SHALL have parameter GROUP_SIZE, default 4: vertices averaged per output; legal values are 2, 4 and 8.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 SHALL have these ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle run request
- num_groups  in  ADDR_W  groups to process
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- idx_en/idx_a  out  1/ADDR_W  index RAM read port
- idx_do  in  DATA_W  index RAM data, valid 1 cycle after idx_en
- vtx_en/vtx_a  out  1/ADDR_W  vertex RAM read port
- vtx_do  in  DATA_W  vertex RAM data, valid 1 cycle after vtx_en
- out_en/out_a  out  1/ADDR_W  result RAM port
- out_we  out  DATA_W/8  result byte enables
- out_di  out  DATA_W  packed averaged vertex

Function
REQ-007 SHALL use FSM states IDLE, IDX_RD, VTX_RD, ACC, WR, DONE.
REQ-008 SHALL, in IDLE on start=1, latch num_groups, clear group g, member k and the accumulators, and go to IDX_RD, or to DONE if num_groups=0.
REQ-009 SHALL ignore start in every state other than IDLE.
REQ-010 SHALL, in IDX_RD, drive idx_en=1 and idx_a=(g*GROUP_SIZE+k) mod 2^ADDR_W.
REQ-011 SHALL, in VTX_RD, drive vtx_en=1 and vtx_a=idx_do[ADDR_W-1:0]; upper index bits are ignored.
REQ-012 SHALL, in ACC, add sign-extended x/y/z of vtx_do into three accumulators of width COORD_W+log2(GROUP_SIZE), with no overflow possible.
REQ-013 SHALL, in ACC, go to IDX_RD with k+1 if k<GROUP_SIZE-1, else to WR.
REQ-014 SHALL, in WR, drive out_en=1, out_we all ones, out_a=g, and out_di=packed (accumulator >>> log2(GROUP_SIZE)), i.e. floor rounding, truncated to COORD_W.
REQ-015 SHALL, in WR, clear the accumulators and k, then go to IDX_RD with g+1 if g+1<num_groups, else to DONE.
REQ-016 SHALL, in DONE, assert done=1 for exactly one cycle with busy=0, then return to IDLE.
REQ-017 SHALL hold busy=1 in every state except IDLE and DONE.
REQ-018 SHALL make the done pulse exactly num_groups*(3*GROUP_SIZE+1)+1 cycles after the start-sampling edge.
REQ-019 SHALL drive all enables and strobes to 0 whenever they are not asserted by the rules above.
REQ-020 SHALL let idx_a wrap modulo 2^ADDR_W with no error.
REQ-021 SHALL process num_groups=2^ADDR_W-1 without counter overflow.

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force state=IDLE and busy, done, idx_en, vtx_en, out_en, out_we, idx_a, vtx_a, out_a, out_di, all counters and accumulators to 0.
REQ-023 SHALL, on reset mid-run, abort with no further RAM access and no done pulse; a new start is accepted in the first cycle after rst_n rises.

Structure
REQ-024 SHALL place the state enum, field-offset constants and pack/unpack functions in a shared package mesh_pkg.
REQ-025 SHALL implement the three-lane signed accumulate-and-shift datapath as sub-module coord_accum, parametrised by COORD_W and GROUP_SIZE.

Verification
REQ-026 Basic run: GROUP_SIZE=4, idx[0..3]=0,1,2,3, vertices (4,8,12),(8,8,12),(12,8,12),(0,8,12), num_groups=1 -> a single write out_a=0 with out_di packing (6,8,12); done 14 cycles after start.
REQ-027 Floor rounding: group with x coordinates -1,-2,-1,-1 -> result x=-2 (0x3FE in a 10-bit field).
REQ-028 Zero groups: num_groups=0 -> done on the next cycle, busy never 1, no out_en.
REQ-029 Busy start: start pulsed while busy -> output sequence and done timing identical to a single start.
REQ-030 Mid-run reset: rst_n low during group 1 of 3 -> all outputs 0 immediately; no done; a fresh run afterwards gives correct results.
REQ-031 Pair mode: GROUP_SIZE=2, 300 groups -> last write at out_a=299, idx_a wraps past 511 to 0, done at cycle 2101.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared types and coordinate packing helpers for the mesh averaging engine.
// A vertex word holds x, y and z as equal-width signed fields, x in the top lane.
package mesh_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIdxRd,
    StVtxRd,
    StAcc,
    StWr,
    StDone
  } state_e;

  localparam int unsigned NumLanes  = 3;
  localparam int unsigned LaneX     = 2;
  localparam int unsigned LaneY     = 1;
  localparam int unsigned LaneZ     = 0;
  localparam int unsigned MaxCoordW = 21;
  localparam int unsigned MaxWordW  = 64;

  function automatic int unsigned field_lsb(input int unsigned lane, input int unsigned cw);
    return lane * cw;
  endfunction

  function automatic logic [MaxCoordW-1:0] coord_mask(input int unsigned cw);
    return (MaxCoordW'(1) << cw) - MaxCoordW'(1);
  endfunction

  // Returns the raw field zero-extended; callers truncate to their coordinate width.
  function automatic logic [MaxCoordW-1:0] unpack_coord(input logic [MaxWordW-1:0] word,
                                                         input int unsigned       lane,
                                                         input int unsigned       cw);
    logic [MaxWordW-1:0] shifted;
    shifted = word >> field_lsb(lane, cw);
    return MaxCoordW'(shifted) & coord_mask(cw);
  endfunction

  function automatic logic [MaxWordW-1:0] pack_coords(input logic [MaxCoordW-1:0] x,
                                                       input logic [MaxCoordW-1:0] y,
                                                       input logic [MaxCoordW-1:0] z,
                                                       input int unsigned          cw);
    logic [MaxCoordW-1:0] m;
    m = coord_mask(cw);
    return (MaxWordW'(x & m) << field_lsb(LaneX, cw)) |
           (MaxWordW'(y & m) << field_lsb(LaneY, cw)) |
           (MaxWordW'(z & m) << field_lsb(LaneZ, cw));
  endfunction

endpackage

// File: rtl/coord_accum.sv
// Three-lane signed accumulator; the output is each sum divided by GROUP_SIZE
// with floor rounding, truncated back to the coordinate width.
module coord_accum
  import mesh_pkg::*;
#(
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned GROUP_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 add,
  input  logic [3*COORD_W-1:0] vtx,
  output logic [3*COORD_W-1:0] avg
);

  localparam int unsigned Shift = $clog2(GROUP_SIZE);
  localparam int unsigned AccW  = COORD_W + Shift;
  localparam int unsigned PackW = 3 * COORD_W;

  logic        [COORD_W-1:0] field [NumLanes];
  logic signed [AccW-1:0]    ext   [NumLanes];
  logic signed [AccW-1:0]    acc_q [NumLanes];
  logic        [COORD_W-1:0] mean  [NumLanes];

  always_comb begin
    for (int unsigned l = 0; l < NumLanes; l++) begin
      field[l] = COORD_W'(unpack_coord(MaxWordW'(vtx), l, COORD_W));
      ext[l]   = {{Shift{field[l][COORD_W-1]}}, field[l]};
      // Arithmetic shift of a signed sum gives floor division by a power of two.
      mean[l]  = COORD_W'(acc_q[l] >>> Shift);
    end
    avg = PackW'(pack_coords(MaxCoordW'(mean[LaneX]), MaxCoordW'(mean[LaneY]),
                             MaxCoordW'(mean[LaneZ]), COORD_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned l = 0; l < NumLanes; l++) acc_q[l] <= '0;
    end else if (clr) begin
      for (int unsigned l = 0; l < NumLanes; l++) acc_q[l] <= '0;
    end else if (add) begin
      for (int unsigned l = 0; l < NumLanes; l++) acc_q[l] <= acc_q[l] + ext[l];
    end
  end

endmodule

// File: rtl/mesh_avg_engine.sv
// Averages groups of GROUP_SIZE indexed vertices into a result RAM, one word per group.
// Each member costs an index read, a vertex read and an accumulate; each group one write.
module mesh_avg_engine
  import mesh_pkg::*;
#(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned GROUP_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   num_groups,
  output logic                busy,
  output logic                done,
  output logic                idx_en,
  output logic [ADDR_W-1:0]   idx_a,
  input  logic [DATA_W-1:0]   idx_do,
  output logic                vtx_en,
  output logic [ADDR_W-1:0]   vtx_a,
  input  logic [DATA_W-1:0]   vtx_do,
  output logic                out_en,
  output logic [ADDR_W-1:0]   out_a,
  output logic [DATA_W/8-1:0] out_we,
  output logic [DATA_W-1:0]   out_di
);

  localparam int unsigned GrpLog = $clog2(GROUP_SIZE);
  localparam int unsigned PackW  = 3 * COORD_W;
  localparam logic [GrpLog-1:0] KLast = GrpLog'(GROUP_SIZE - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   g_q, g_d;
  logic [GrpLog-1:0]   k_q, k_d;
  logic [ADDR_W-1:0]   num_q, num_d;
  logic [ADDR_W:0]     g_inc;
  logic                acc_clr, acc_add;
  logic [PackW-1:0]    avg;
  logic                unused_bits;

  // Upper index bits and vertex padding bits carry no information.
  assign unused_bits = ^{idx_do[DATA_W-1:ADDR_W], vtx_do[DATA_W-1:PackW]};

  assign g_inc = {1'b0, g_q} + (ADDR_W + 1)'(1);

  coord_accum #(
    .COORD_W    (COORD_W),
    .GROUP_SIZE (GROUP_SIZE)
  ) u_coord_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .add   (acc_add),
    .vtx   (vtx_do[PackW-1:0]),
    .avg   (avg)
  );

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    k_d     = k_q;
    num_d   = num_q;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    idx_en  = 1'b0;
    idx_a   = '0;
    vtx_en  = 1'b0;
    vtx_a   = '0;
    out_en  = 1'b0;
    out_a   = '0;
    out_we  = '0;
    out_di  = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d   = num_groups;
          g_d     = '0;
          k_d     = '0;
          acc_clr = 1'b1;
          state_d = (num_groups == '0) ? StDone : StIdxRd;
        end
      end
      StIdxRd: begin
        busy    = 1'b1;
        idx_en  = 1'b1;
        // g*GROUP_SIZE+k, wrapping modulo the RAM depth.
        idx_a   = ADDR_W'({g_q, k_q});
        state_d = StVtxRd;
      end
      StVtxRd: begin
        busy    = 1'b1;
        vtx_en  = 1'b1;
        vtx_a   = idx_do[ADDR_W-1:0];
        state_d = StAcc;
      end
      StAcc: begin
        busy    = 1'b1;
        acc_add = 1'b1;
        if (k_q != KLast) begin
          k_d     = k_q + GrpLog'(1);
          state_d = StIdxRd;
        end else begin
          state_d = StWr;
        end
      end
      StWr: begin
        busy    = 1'b1;
        out_en  = 1'b1;
        out_we  = '1;
        out_a   = g_q;
        out_di  = DATA_W'(avg);
        acc_clr = 1'b1;
        k_d     = '0;
        if (g_inc < {1'b0, num_q}) begin
          g_d     = g_inc[ADDR_W-1:0];
          state_d = StIdxRd;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      g_q     <= '0;
      k_q     <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      k_q     <= k_d;
      num_q   <= num_d;
    end
  end

endmodule

// File: tb/tb_mesh_avg_engine.sv
// Bench for mesh_avg_engine: a GROUP_SIZE=4 instance and a GROUP_SIZE=2 instance,
// each with behavioural RAMs and a write scoreboard filled from a reference model.
module tb_mesh_avg_engine;

  typedef struct {
    logic [8:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic [8:0]  num0 = '0, num1 = '0;
  logic        busy0, done0, idx_en0, vtx_en0, out_en0;
  logic        busy1, done1, idx_en1, vtx_en1, out_en1;
  logic [8:0]  idx_a0, vtx_a0, out_a0, idx_a1, vtx_a1, out_a1;
  logic [3:0]  out_we0, out_we1;
  logic [31:0] idx_do0, vtx_do0, out_di0, idx_do1, vtx_do1, out_di1;

  logic [31:0] idx_mem0 [512];
  logic [31:0] vtx_mem0 [512];
  logic [31:0] idx_mem1 [512];
  logic [31:0] vtx_mem1 [512];

  wr_t sb0[$];
  wr_t sb1[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  wr_cnt0 = 0, wr_cnt1 = 0;
  int  last_a1 = -1, prev_idx1 = -1;
  bit  wrap_seen1 = 1'b0;

  always #5 clk = ~clk;

  mesh_avg_engine #(.ADDR_W(9), .DATA_W(32), .COORD_W(10), .GROUP_SIZE(4)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .start (start0), .num_groups (num0),
    .busy (busy0), .done (done0),
    .idx_en (idx_en0), .idx_a (idx_a0), .idx_do (idx_do0),
    .vtx_en (vtx_en0), .vtx_a (vtx_a0), .vtx_do (vtx_do0),
    .out_en (out_en0), .out_a (out_a0), .out_we (out_we0), .out_di (out_di0)
  );

  mesh_avg_engine #(.ADDR_W(9), .DATA_W(32), .COORD_W(10), .GROUP_SIZE(2)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .start (start1), .num_groups (num1),
    .busy (busy1), .done (done1),
    .idx_en (idx_en1), .idx_a (idx_a1), .idx_do (idx_do1),
    .vtx_en (vtx_en1), .vtx_a (vtx_a1), .vtx_do (vtx_do1),
    .out_en (out_en1), .out_a (out_a1), .out_we (out_we1), .out_di (out_di1)
  );

  always @(posedge clk) begin
    if (idx_en0) idx_do0 <= idx_mem0[idx_a0];
    if (vtx_en0) vtx_do0 <= vtx_mem0[vtx_a0];
    if (idx_en1) idx_do1 <= idx_mem1[idx_a1];
    if (vtx_en1) vtx_do1 <= vtx_mem1[vtx_a1];
  end

  function automatic logic [31:0] pack_v(input int x, input int y, input int z);
    return {2'b00, x[9:0], y[9:0], z[9:0]};
  endfunction

  // Reference: mean of the indexed vertices, floor-rounded by explicit division.
  function automatic logic [31:0] model_avg(input bit sel, input int gs, input int g);
    int          s [3];
    int          ia, q;
    logic [31:0] iw, vw, r;
    logic [9:0]  f;
    s = '{0, 0, 0};
    for (int k = 0; k < gs; k++) begin
      ia = (g * gs + k) % 512;
      iw = sel ? idx_mem1[ia] : idx_mem0[ia];
      vw = sel ? vtx_mem1[iw[8:0]] : vtx_mem0[iw[8:0]];
      for (int l = 0; l < 3; l++) begin
        f = vw[l*10 +: 10];
        s[l] += int'($signed(f));
      end
    end
    r = '0;
    for (int l = 0; l < 3; l++) begin
      q = s[l] / gs;
      if ((s[l] % gs) != 0 && s[l] < 0) q--;
      r[l*10 +: 10] = q[9:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin : mon0
    wr_t e;
    if (out_en0) begin
      wr_cnt0++;
      n_cmp++;
      if (sb0.size() == 0) begin
        n_fail++;
        $display("FAIL dut0_unexpected_write: got a=%0d d=%h, required no write", out_a0, out_di0);
      end else begin
        e = sb0.pop_front();
        if ({out_a0, out_di0} !== {e.a, e.d}) begin
          n_fail++;
          $display("FAIL dut0_write: got a=%0d d=%h, required a=%0d d=%h",
                   out_a0, out_di0, e.a, e.d);
        end
      end
      n_cmp++;
      if (out_we0 !== 4'hF) begin
        n_fail++;
        $display("FAIL dut0_out_we: got %h, required f", out_we0);
      end
    end
  end

  always @(negedge clk) begin : mon1
    wr_t e;
    if (idx_en1) begin
      if (prev_idx1 == 511 && idx_a1 == 9'd0) wrap_seen1 = 1'b1;
      prev_idx1 = int'(idx_a1);
    end
    if (out_en1) begin
      wr_cnt1++;
      last_a1 = int'(out_a1);
      n_cmp++;
      if (sb1.size() == 0) begin
        n_fail++;
        $display("FAIL dut1_unexpected_write: got a=%0d d=%h, required no write", out_a1, out_di1);
      end else begin
        e = sb1.pop_front();
        if ({out_a1, out_di1} !== {e.a, e.d}) begin
          n_fail++;
          $display("FAIL dut1_write: got a=%0d d=%h, required a=%0d d=%h",
                   out_a1, out_di1, e.a, e.d);
        end
      end
    end
  end

  task automatic pulse_start0(input logic [8:0] ng);
    @(negedge clk);
    num0   = ng;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
  endtask

  // Counts edges after the start edge up to the one that samples done high.
  task automatic wait_done0(input int bound, output int cyc, output bit busy_seen);
    logic d;
    cyc = 0;
    busy_seen = 1'b0;
    forever begin
      @(negedge clk);
      d = done0;
      if (busy0) busy_seen = 1'b1;
      @(posedge clk);
      cyc++;
      if (d || cyc >= bound) break;
    end
  endtask

  task automatic fill_random0(input int n_idx);
    for (int i = 0; i < 512; i++) vtx_mem0[i] = $urandom() & 32'h3FFF_FFFF;
    for (int i = 0; i < n_idx; i++) idx_mem0[i] = $urandom();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy0, done0, idx_en0, vtx_en0, out_en0, out_we0} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl0: got %b, required 0",
               {busy0, done0, idx_en0, vtx_en0, out_en0, out_we0});
    end
    n_cmp++;
    if ({idx_a0, vtx_a0, out_a0, out_di0} !== 59'd0) begin
      n_fail++;
      $display("FAIL reset_data0: got %h, required 0", {idx_a0, vtx_a0, out_a0, out_di0});
    end
    n_cmp++;
    if ({busy1, done1, idx_en1, vtx_en1, out_en1, out_we1, out_di1} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_dut1: got %h, required 0",
               {busy1, done1, idx_en1, vtx_en1, out_en1, out_we1, out_di1});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy0, done0} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy/done=%b, required 00", {busy0, done0});
    end
  endtask

  task automatic test_basic();
    int cyc;
    int w;
    bit bs;
    for (int i = 0; i < 4; i++) idx_mem0[i] = i;
    vtx_mem0[0] = pack_v(4, 8, 12);
    vtx_mem0[1] = pack_v(8, 8, 12);
    vtx_mem0[2] = pack_v(12, 8, 12);
    vtx_mem0[3] = pack_v(0, 8, 12);
    sb0.push_back('{a: 9'd0, d: {2'b00, 10'd6, 10'd8, 10'd12}});
    w = wr_cnt0;
    pulse_start0(9'd1);
    n_cmp++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b, required 1", busy0);
    end
    wait_done0(200, cyc, bs);
    n_cmp++;
    if (cyc != 14) begin
      n_fail++;
      $display("FAIL basic_done_cycle: got %0d, required 14", cyc);
    end
    n_cmp++;
    if (wr_cnt0 - w != 1 || sb0.size() != 0) begin
      n_fail++;
      $display("FAIL basic_write_count: got %0d writes, %0d pending, required 1, 0",
               wr_cnt0 - w, sb0.size());
    end
    @(negedge clk);
    n_cmp++;
    if (done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_width: got %b, required 0", done0);
    end
  endtask

  task automatic test_floor();
    int cyc;
    bit bs;
    // Upper index bits are junk and must be ignored.
    idx_mem0[0] = 32'hABCD_E00A;
    idx_mem0[1] = 32'h1234_600B;
    idx_mem0[2] = 32'hFFFF_FE0C;
    idx_mem0[3] = 32'h0000_020D;
    vtx_mem0[10] = pack_v(-1, 3, -3);
    vtx_mem0[11] = pack_v(-2, 4, 0);
    vtx_mem0[12] = pack_v(-1, 5, 0);
    vtx_mem0[13] = pack_v(-1, 6, 0);
    sb0.push_back('{a: 9'd0, d: {2'b00, 10'h3FE, 10'd4, 10'h3FF}});
    pulse_start0(9'd1);
    wait_done0(200, cyc, bs);
    n_cmp++;
    if (cyc != 14 || sb0.size() != 0) begin
      n_fail++;
      $display("FAIL floor_run: got cycle %0d pending %0d, required 14, 0", cyc, sb0.size());
    end
  endtask

  task automatic test_zero_groups();
    int cyc;
    int w;
    bit bs;
    w = wr_cnt0;
    pulse_start0(9'd0);
    n_cmp++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_busy_early: got %b, required 0", busy0);
    end
    wait_done0(50, cyc, bs);
    n_cmp++;
    if (cyc != 1) begin
      n_fail++;
      $display("FAIL zero_done_cycle: got %0d, required 1", cyc);
    end
    n_cmp++;
    if (bs || wr_cnt0 != w) begin
      n_fail++;
      $display("FAIL zero_activity: got busy_seen=%0d writes=%0d, required 0, 0", bs, wr_cnt0 - w);
    end
  endtask

  task automatic test_busy_start();
    int   cyc;
    int   w;
    logic d;
    fill_random0(12);
    for (int g = 0; g < 3; g++) sb0.push_back('{a: 9'(g), d: model_avg(1'b0, 4, g)});
    w = wr_cnt0;
    pulse_start0(9'd3);
    cyc = 0;
    forever begin
      @(negedge clk);
      d = done0;
      if (cyc == 10 || cyc == 25) begin
        start0 = 1'b1;
        num0   = 9'd5;
      end else begin
        start0 = 1'b0;
      end
      @(posedge clk);
      cyc++;
      if (d || cyc >= 300) break;
    end
    #1 start0 = 1'b0;
    n_cmp++;
    if (cyc != 40) begin
      n_fail++;
      $display("FAIL busy_start_done_cycle: got %0d, required 40", cyc);
    end
    n_cmp++;
    if (wr_cnt0 - w != 3 || sb0.size() != 0) begin
      n_fail++;
      $display("FAIL busy_start_writes: got %0d writes %0d pending, required 3, 0",
               wr_cnt0 - w, sb0.size());
    end
    @(negedge clk);
    n_cmp++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_restarted: got busy %b, required 0", busy0);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    int w;
    bit bs;
    bit done_seen;
    fill_random0(12);
    for (int g = 0; g < 3; g++) sb0.push_back('{a: 9'(g), d: model_avg(1'b0, 4, g)});
    pulse_start0(9'd3);
    repeat (18) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy0, done0, idx_en0, vtx_en0, out_en0, out_we0, idx_a0, vtx_a0, out_a0, out_di0}
        !== 68'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h, required 0",
               {busy0, done0, idx_en0, vtx_en0, out_en0, out_we0, idx_a0, vtx_a0, out_a0, out_di0});
    end
    n_cmp++;
    if (sb0.size() != 2) begin
      n_fail++;
      $display("FAIL mid_reset_progress: got %0d pending, required 2", sb0.size());
    end
    sb0.delete();
    w = wr_cnt0;
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done0 || idx_en0 || vtx_en0) done_seen = 1'b1;
    end
    // Fresh run requested in the first cycle after reset releases.
    for (int g = 0; g < 2; g++) sb0.push_back('{a: 9'(g), d: model_avg(1'b0, 4, g)});
    rst_n  = 1'b1;
    num0   = 9'd2;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    n_cmp++;
    if (done_seen || wr_cnt0 != w) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: got activity=%0d writes=%0d, required 0, 0",
               done_seen, wr_cnt0 - w);
    end
    n_cmp++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_restart_busy: got %b, required 1", busy0);
    end
    wait_done0(200, cyc, bs);
    n_cmp++;
    if (cyc != 27 || sb0.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset_rerun: got cycle %0d pending %0d, required 27, 0", cyc, sb0.size());
    end
  endtask

  task automatic test_pair_mode();
    int   cyc;
    int   w;
    logic d;
    for (int i = 0; i < 512; i++) begin
      idx_mem1[i] = $urandom();
      vtx_mem1[i] = $urandom() & 32'h3FFF_FFFF;
    end
    for (int g = 0; g < 300; g++) sb1.push_back('{a: 9'(g), d: model_avg(1'b1, 2, g)});
    w = wr_cnt1;
    @(negedge clk);
    num1   = 9'd300;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      d = done1;
      @(posedge clk);
      cyc++;
      if (d || cyc >= 5000) break;
    end
    n_cmp++;
    if (cyc != 2101) begin
      n_fail++;
      $display("FAIL pair_done_cycle: got %0d, required 2101", cyc);
    end
    n_cmp++;
    if (wr_cnt1 - w != 300 || sb1.size() != 0) begin
      n_fail++;
      $display("FAIL pair_writes: got %0d writes %0d pending, required 300, 0",
               wr_cnt1 - w, sb1.size());
    end
    n_cmp++;
    if (last_a1 != 299) begin
      n_fail++;
      $display("FAIL pair_last_addr: got %0d, required 299", last_a1);
    end
    n_cmp++;
    if (!wrap_seen1) begin
      n_fail++;
      $display("FAIL pair_idx_wrap: got no 511->0 step, required one");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_floor();
    test_zero_groups();
    test_busy_start();
    test_mid_reset();
    test_pair_mode();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
